bus_arbiter: RTL

Two-master, round-robin arbiter that shares the single gpiomem port between core0 and core1.
- Owns the request/grant handshake with each core.
- Muxes the granted core's address, data and rw onto the memory side, and routes memory read data back to the owner only.
- Enforces a maximum tenure so one core cannot starve the other.
- Inserts a one-cycle bus turnaround between owners.

---
 rtl/bus_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared gpiomem port, with tenure
// limit and a one-cycle turnaround between owners.
module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core0_request,
    output logic              core0_grant,
    input  logic              core0_rw,
    input  logic [ADDR_W-1:0] core0_address,
    input  logic [DATA_W-1:0] core0_data_in,
    output logic [DATA_W-1:0] core0_data_out,
    input  logic              core1_request,
    output logic              core1_grant,
    input  logic              core1_rw,
    input  logic [ADDR_W-1:0] core1_address,
    input  logic [DATA_W-1:0] core1_data_in,
    output logic [DATA_W-1:0] core1_data_out,
    output logic [ADDR_W-1:0] RAM_address,
    output logic [DATA_W-1:0] RAM_data_in,
    input  logic [DATA_W-1:0] RAM_data_out,
    output logic              rw,
    output logic [1:0]        owner,
    output logic              preempt
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, RELEASE} state_t;

    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
    localparam logic       PREEMPT_ON = (MAX_HOLD != 0);

    state_t     state;
    logic [7:0] hold;
    logic       last_owner;   // 0 = core0, 1 = core1
    logic       pick0;
    logic       pick1;
    logic       hold_expired;

    // Ties go to whichever core did not own the bus last.
    assign pick0 = core0_request && (!core1_request || last_owner);
    assign pick1 = core1_request && (!core0_request || !last_owner);
    assign hold_expired = PREEMPT_ON && (hold == HOLD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            core0_grant <= 1'b0;
            core1_grant <= 1'b0;
            owner       <= 2'b00;
            preempt     <= 1'b0;
            hold        <= '0;
            last_owner  <= 1'b1;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE, RELEASE: begin
                    hold <= '0;
                    if (pick0) begin
                        state       <= OWN0;
                        core0_grant <= 1'b1;
                        core1_grant <= 1'b0;
                        owner       <= 2'b01;
                        last_owner  <= 1'b0;
                    end else if (pick1) begin
                        state       <= OWN1;
                        core0_grant <= 1'b0;
                        core1_grant <= 1'b1;
                        owner       <= 2'b10;
                        last_owner  <= 1'b1;
                    end else begin
                        state       <= IDLE;
                        core0_grant <= 1'b0;
                        core1_grant <= 1'b0;
                        owner       <= 2'b00;
                    end
                end
                OWN0: begin
                    if (!core0_request || (hold_expired && core1_request)) begin
                        state       <= RELEASE;
                        core0_grant <= 1'b0;
                        owner       <= 2'b00;
                        preempt     <= core0_request;
                    end else if (hold != 8'hFF) begin
                        hold <= hold + 8'd1;
                    end
                end
                OWN1: begin
                    if (!core1_request || (hold_expired && core0_request)) begin
                        state       <= RELEASE;
                        core1_grant <= 1'b0;
                        owner       <= 2'b00;
                        preempt     <= core1_request;
                    end else if (hold != 8'hFF) begin
                        hold <= hold + 8'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    core0_grant <= 1'b0;
                    core1_grant <= 1'b0;
                    owner       <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        RAM_address = '0;
        RAM_data_in = '0;
        rw          = 1'b0;
        case (state)
            OWN0: begin
                RAM_address = core0_address;
                RAM_data_in = core0_data_in;
                rw          = core0_rw;
            end
            OWN1: begin
                RAM_address = core1_address;
                RAM_data_in = core1_data_in;
                rw          = core1_rw;
            end
            default: ;
        endcase
    end

    assign core0_data_out = (owner == 2'b01) ? RAM_data_out : '0;
    assign core1_data_out = (owner == 2'b10) ? RAM_data_out : '0;

endmodule
